wishbone_timer: RTL and testbench



---
 rtl/wishbone_if.sv | 21 ++
 rtl/wishbone_timer.sv | 153 +++++++++++++++
 tb/tb_wishbone_timer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_if.sv
// Classic Wishbone bus bundle (32-bit data, byte selects) shared by the SoC switch and its slaves.
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack
    );
endinterface

// File: rtl/wishbone_timer.sv
// Memory-mapped 64-bit machine timer: prescaled mtime, mtimecmp compare and a level interrupt.
module wishbone_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clk,
    input  logic       reset,
    wishbone_if.slave  wishbone,
    output logic       o_irq
);

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 64;
    localparam int unsigned PW = 16;
    localparam int unsigned BW = DW / 8;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        OFF_MTIME_LO    = 3'd0,
        OFF_MTIME_HI    = 3'd1,
        OFF_MTIMECMP_LO = 3'd2,
        OFF_MTIMECMP_HI = 3'd3,
        OFF_CTRL        = 3'd4,
        OFF_STATUS      = 3'd5,
        OFF_RSVD6       = 3'd6,
        OFF_RSVD7       = 3'd7
    } reg_off_e;

    logic [TW-1:0] mtime_q,     mtime_d;
    logic [TW-1:0] mtimecmp_q,  mtimecmp_d;
    logic [DW-1:0] hi_shadow_q, hi_shadow_d;
    logic [PW-1:0] pcnt_q,      pcnt_d;
    logic          en_q,        en_d;
    logic          irq_en_q,    irq_en_d;
    logic          ack_q,       ack_d;
    logic [DW-1:0] dat_r_q,     dat_r_d;

    logic     accept_c;
    logic     tick_c;
    logic     cmp_ge_c;
    reg_off_e off_c;
    logic     unused_adr_c;

    // Byte-lane merge of a write into an existing 32-bit register image.
    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0] old_val,
        input logic [DW-1:0] wr_val,
        input logic [BW-1:0] sel
    );
        logic [DW-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(BW); i++) begin
            if (sel[i]) begin
                res[i*8 +: 8] = wr_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    assign accept_c     = wishbone.cyc & wishbone.stb & ~ack_q;
    assign off_c        = reg_off_e'(wishbone.adr[4:2]);
    assign tick_c       = en_q && (pcnt_q == PCNT_MAX);
    assign cmp_ge_c     = (mtime_q >= mtimecmp_q);
    assign unused_adr_c = ^{wishbone.adr[31:5], wishbone.adr[1:0]};

    always_comb begin
        mtime_d     = tick_c ? (mtime_q + TW'(1)) : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        hi_shadow_d = hi_shadow_q;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        dat_r_d     = dat_r_q;
        ack_d       = accept_c;
        pcnt_d      = pcnt_q;

        if (accept_c && wishbone.we) begin
            // A bus write to either mtime half overrides the tick for the full 64 bits.
            unique case (off_c)
                OFF_MTIME_LO:
                    mtime_d = {mtime_q[TW-1:DW],
                               merge_bytes(mtime_q[DW-1:0], wishbone.dat_w, wishbone.sel)};
                OFF_MTIME_HI:
                    mtime_d = {merge_bytes(mtime_q[TW-1:DW], wishbone.dat_w, wishbone.sel),
                               mtime_q[DW-1:0]};
                OFF_MTIMECMP_LO:
                    mtimecmp_d[DW-1:0]  = merge_bytes(mtimecmp_q[DW-1:0], wishbone.dat_w,
                                                      wishbone.sel);
                OFF_MTIMECMP_HI:
                    mtimecmp_d[TW-1:DW] = merge_bytes(mtimecmp_q[TW-1:DW], wishbone.dat_w,
                                                      wishbone.sel);
                OFF_CTRL: begin
                    if (wishbone.sel[0]) begin
                        en_d     = wishbone.dat_w[0];
                        irq_en_d = wishbone.dat_w[1];
                    end
                end
                OFF_STATUS, OFF_RSVD6, OFF_RSVD7: begin
                end
                default: begin
                end
            endcase
        end

        if (accept_c && !wishbone.we) begin
            unique case (off_c)
                OFF_MTIME_LO: begin
                    dat_r_d     = mtime_q[DW-1:0];
                    hi_shadow_d = mtime_q[TW-1:DW];
                end
                OFF_MTIME_HI:    dat_r_d = hi_shadow_q;
                OFF_MTIMECMP_LO: dat_r_d = mtimecmp_q[DW-1:0];
                OFF_MTIMECMP_HI: dat_r_d = mtimecmp_q[TW-1:DW];
                OFF_CTRL:        dat_r_d = {(DW-2)'(0), irq_en_q, en_q};
                OFF_STATUS:      dat_r_d = {(DW-1)'(0), cmp_ge_c};
                OFF_RSVD6, OFF_RSVD7: dat_r_d = '0;
                default:         dat_r_d = '0;
            endcase
        end

        // Prescaler only advances while EN is set both now and next cycle.
        if (!en_q || !en_d || tick_c) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            hi_shadow_q <= '0;
            pcnt_q      <= '0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            ack_q       <= 1'b0;
            dat_r_q     <= '0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            hi_shadow_q <= hi_shadow_d;
            pcnt_q      <= pcnt_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            ack_q       <= ack_d;
            dat_r_q     <= dat_r_d;
        end
    end

    assign wishbone.ack   = ack_q;
    assign wishbone.dat_r = dat_r_q;
    assign o_irq          = irq_en_q & cmp_ge_c;

endmodule

// File: tb/tb_wishbone_timer.sv
// Randomized bench for wishbone_timer; reference model expresses mtime as a closed-form tick count.
module tb_wishbone_timer;

    localparam int unsigned P = 4;

    logic clk = 1'b0;
    logic reset;
    logic o_irq;

    wishbone_if bus();

    wishbone_timer #(.PRESCALE(P)) dut (
        .clk      (clk),
        .reset    (reset),
        .wishbone (bus),
        .o_irq    (o_irq)
    );

    always #5 clk = ~clk;

    longint edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mtime = base + number of ticks after base_edge; ticks fall on edges en_edge + k*P, k>=1.
    logic [63:0] m_base;
    logic [63:0] m_cmp;
    longint      m_base_edge;
    longint      m_en_edge;
    bit          m_en;
    bit          m_irq_en;
    logic [31:0] m_shadow;

    function automatic void m_reset(input longint e);
        m_base      = 64'd0;
        m_cmp       = '1;
        m_base_edge = e;
        m_en_edge   = e;
        m_en        = 1'b0;
        m_irq_en    = 1'b0;
        m_shadow    = 32'd0;
    endfunction

    function automatic logic [63:0] m_mtime(input longint e);
        longint n;
        if (!m_en || e <= m_base_edge) return m_base;
        n = (e - m_en_edge) / longint'(P) - (m_base_edge - m_en_edge) / longint'(P);
        return m_base + 64'(n);
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off, input longint w);
        logic [63:0] mt;
        logic [31:0] r;
        mt = m_mtime(w - 1);
        case (off)
            3'd0: begin r = mt[31:0]; m_shadow = mt[63:32]; end
            3'd1: r = m_shadow;
            3'd2: r = m_cmp[31:0];
            3'd3: r = m_cmp[63:32];
            3'd4: r = {30'd0, m_irq_en, m_en};
            3'd5: r = {31'd0, (mt >= m_cmp)};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic void m_write(input logic [2:0] off, input logic [3:0] s,
                                    input logic [31:0] d, input longint w);
        logic [63:0] pre;
        case (off)
            3'd0: begin
                pre = m_mtime(w - 1);
                m_base = {pre[63:32], m_merge(pre[31:0], d, s)};
                m_base_edge = w;
            end
            3'd1: begin
                pre = m_mtime(w - 1);
                m_base = {m_merge(pre[63:32], d, s), pre[31:0]};
                m_base_edge = w;
            end
            3'd2: m_cmp[31:0]  = m_merge(m_cmp[31:0], d, s);
            3'd3: m_cmp[63:32] = m_merge(m_cmp[63:32], d, s);
            3'd4: begin
                m_base = m_mtime(w);
                m_base_edge = w;
                if (s[0]) begin
                    if (!m_en && d[0]) m_en_edge = w;
                    m_en     = d[0];
                    m_irq_en = d[1];
                end
            end
            default: ;
        endcase
    endfunction

    function automatic bit m_irq(input longint e);
        return m_irq_en && (m_mtime(e) >= m_cmp);
    endfunction

    // One bus transfer; returns accept edge and observations in the ack cycle and the one after.
    task automatic xfer(input bit we, input logic [2:0] off, input logic [3:0] sel,
                        input logic [31:0] dat, output logic [31:0] rd, output longint w,
                        output logic ack0, output logic ack1, output logic irq0);
        @(negedge clk);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.sel   = sel;
        bus.dat_w = dat;
        bus.adr   = {27'($urandom), off, 2'($urandom)};
        @(posedge clk); #1;
        w    = edge_cnt;
        ack0 = bus.ack;
        rd   = bus.dat_r;
        irq0 = o_irq;
        @(posedge clk); #1;
        ack1 = bus.ack;
        @(negedge clk);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
    endtask

    logic [31:0] rd, exp32;
    longint      w;
    logic        a0, a1, irq0;

    task automatic test_reset();
        longint r;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 r = edge_cnt;
        n_checks += 3;
        if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
        if (bus.dat_r !== 32'd0) begin n_fail++; $display("FAIL reset_dat_r: got %h want 0", bus.dat_r); end
        if (o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", o_irq); end
        @(negedge clk) reset = 1'b0;
        m_reset(r);
        for (int off = 0; off < 8; off++) begin
            xfer(1'b0, 3'(off), 4'hF, 32'd0, rd, w, a0, a1, irq0);
            exp32 = (off == 2 || off == 3) ? 32'hFFFF_FFFF : 32'd0;
            n_checks += 3;
            if (a0 !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ack off%0d: got %b want 1", off, a0); end
            if (a1 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ack_gap off%0d: got %b want 0", off, a1); end
            if (rd !== exp32) begin n_fail++; $display("FAIL reset_rd off%0d: got %h want %h", off, rd, exp32); end
            void'(m_read(3'(off), w));
        end
    endtask

    task automatic test_count();
        logic [31:0] v1;
        xfer(1'b1, 3'd4, 4'hF, 32'd1, rd, w, a0, a1, irq0);
        m_write(3'd4, 4'hF, 32'd1, w);
        repeat (40) @(posedge clk);
        xfer(1'b0, 3'd0, 4'hF, 32'd0, rd, w, a0, a1, irq0);
        exp32 = m_read(3'd0, w);
        n_checks++;
        if (rd !== exp32) begin n_fail++; $display("FAIL count_lo: got %h want %h", rd, exp32); end
        xfer(1'b1, 3'd4, 4'hF, 32'd0, rd, w, a0, a1, irq0);
        m_write(3'd4, 4'hF, 32'd0, w);
        xfer(1'b0, 3'd0, 4'hF, 32'd0, v1, w, a0, a1, irq0);
        exp32 = m_read(3'd0, w);
        n_checks++;
        if (v1 !== exp32) begin n_fail++; $display("FAIL count_stop: got %h want %h", v1, exp32); end
        repeat (20) @(posedge clk);
        xfer(1'b0, 3'd0, 4'hF, 32'd0, rd, w, a0, a1, irq0);
        exp32 = m_read(3'd0, w);
        n_checks += 2;
        if (rd !== exp32) begin n_fail++; $display("FAIL count_frozen_model: got %h want %h", rd, exp32); end
        if (rd !== v1) begin n_fail++; $display("FAIL count_frozen: got %h want %h", rd, v1); end
    endtask

    task automatic test_carry();
        logic [31:0] lo, hi;
        for (int t = 0; t < 4; t++) begin
            xfer(1'b1, 3'd4, 4'hF, 32'd0, rd, w, a0, a1, irq0);          m_write(3'd4, 4'hF, 32'd0, w);
            xfer(1'b1, 3'd1, 4'hF, 32'd0, rd, w, a0, a1, irq0);          m_write(3'd1, 4'hF, 32'd0, w);
            xfer(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFE, rd, w, a0, a1, irq0);  m_write(3'd0, 4'hF, 32'hFFFF_FFFE, w);
            xfer(1'b1, 3'd4, 4'hF, 32'd1, rd, w, a0, a1, irq0);          m_write(3'd4, 4'hF, 32'd1, w);
            repeat ($urandom_range(0, 12)) @(posedge clk);
            xfer(1'b0, 3'd0, 4'hF, 32'd0, lo, w, a0, a1, irq0);
            exp32 = m_read(3'd0, w);
            n_checks++;
            if (lo !== exp32) begin n_fail++; $display("FAIL carry_lo t%0d: got %h want %h", t, lo, exp32); end
            repeat ($urandom_range(0, 9)) @(posedge clk);
            xfer(1'b0, 3'd1, 4'hF, 32'd0, hi, w, a0, a1, irq0);
            exp32 = m_read(3'd1, w);
            n_checks++;
            if (hi !== exp32) begin n_fail++; $display("FAIL carry_hi t%0d: got %h want %h", t, hi, exp32); end
            exp32 = (lo < 32'hFFFF_FFFE) ? 32'd1 : 32'd0;
            n_checks++;
            if (hi !== exp32) begin n_fail++; $display("FAIL carry_snap t%0d: got %h want %h (lo %h)", t, hi, exp32, lo); end
        end
    endtask

    task automatic test_irq();
        bit     rose;
        int     after;
        longint e;
        xfer(1'b1, 3'd4, 4'hF, 32'd0, rd, w, a0, a1, irq0);   m_write(3'd4, 4'hF, 32'd0, w);
        xfer(1'b1, 3'd1, 4'hF, 32'd0, rd, w, a0, a1, irq0);   m_write(3'd1, 4'hF, 32'd0, w);
        xfer(1'b1, 3'd0, 4'hF, 32'd0, rd, w, a0, a1, irq0);   m_write(3'd0, 4'hF, 32'd0, w);
        xfer(1'b1, 3'd3, 4'hF, 32'd0, rd, w, a0, a1, irq0);   m_write(3'd3, 4'hF, 32'd0, w);
        xfer(1'b1, 3'd2, 4'hF, 32'd100, rd, w, a0, a1, irq0); m_write(3'd2, 4'hF, 32'd100, w);
        xfer(1'b1, 3'd4, 4'hF, 32'd3, rd, w, a0, a1, irq0);   m_write(3'd4, 4'hF, 32'd3, w);
        rose  = 1'b0;
        after = 0;
        for (int c = 0; c < 600 && after < 3; c++) begin
            @(posedge clk); #1;
            e = edge_cnt;
            n_checks++;
            if (o_irq !== m_irq(e)) begin
                n_fail++; $display("FAIL irq_level edge%0d: got %b want %b", e, o_irq, m_irq(e));
            end
            if (!rose && o_irq === 1'b1) begin
                rose = 1'b1;
                n_checks++;
                if (m_mtime(e) !== 64'd100) begin
                    n_fail++; $display("FAIL irq_rise_time: got mtime %0d want 100", m_mtime(e));
                end
            end
            if (rose) after++;
        end
        n_checks++;
        if (!rose) begin n_fail++; $display("FAIL irq_timeout: got no rise want rise"); end
        xfer(1'b0, 3'd5, 4'hF, 32'd0, rd, w, a0, a1, irq0);
        n_checks += 2;
        if (rd !== 32'd1) begin n_fail++; $display("FAIL irq_status: got %h want 1", rd); end
        exp32 = m_read(3'd5, w);
        if (rd !== exp32) begin n_fail++; $display("FAIL irq_status_model: got %h want %h", rd, exp32); end
        xfer(1'b1, 3'd2, 4'hF, 32'd1000, rd, w, a0, a1, irq0);
        m_write(3'd2, 4'hF, 32'd1000, w);
        n_checks += 2;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq0); end
        if (irq0 !== m_irq(w)) begin n_fail++; $display("FAIL irq_clear_model: got %b want %b", irq0, m_irq(w)); end
    endtask

    task automatic test_bytes();
        int guard;
        xfer(1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF, rd, w, a0, a1, irq0); m_write(3'd2, 4'hF, 32'hFFFF_FFFF, w);
        xfer(1'b1, 3'd2, 4'b0010, 32'h0000_AB00, rd, w, a0, a1, irq0); m_write(3'd2, 4'b0010, 32'h0000_AB00, w);
        xfer(1'b0, 3'd2, 4'hF, 32'd0, rd, w, a0, a1, irq0);
        void'(m_read(3'd2, w));
        n_checks++;
        if (rd !== 32'hFFFF_ABFF) begin n_fail++; $display("FAIL bytes_sel: got %h want ffffabff", rd); end
        xfer(1'b1, 3'd4, 4'hF, 32'd0, rd, w, a0, a1, irq0); m_write(3'd4, 4'hF, 32'd0, w);
        xfer(1'b1, 3'd4, 4'hF, 32'd1, rd, w, a0, a1, irq0); m_write(3'd4, 4'hF, 32'd1, w);
        repeat (6) @(posedge clk);
        // Line up the next accept edge with a tick edge.
        guard = 0;
        @(negedge clk);
        while (((edge_cnt + 2 - m_en_edge) % longint'(P)) != 0 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        xfer(1'b1, 3'd0, 4'hF, 32'd5, rd, w, a0, a1, irq0); m_write(3'd0, 4'hF, 32'd5, w);
        xfer(1'b0, 3'd0, 4'hF, 32'd0, rd, w, a0, a1, irq0);
        exp32 = m_read(3'd0, w);
        n_checks += 2;
        if (rd !== 32'd5) begin n_fail++; $display("FAIL collide: got %h want 5", rd); end
        if (rd !== exp32) begin n_fail++; $display("FAIL collide_model: got %h want %h", rd, exp32); end
    endtask

    task automatic test_random();
        bit          we;
        logic [2:0]  off;
        logic [3:0]  sel;
        logic [31:0] dat;
        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom);
            off = 3'($urandom);
            sel = 4'($urandom);
            dat = $urandom;
            if (off == 3'd4) dat = dat & 32'h3;
            xfer(we, off, sel, dat, rd, w, a0, a1, irq0);
            n_checks += 3;
            if (a0 !== 1'b1) begin n_fail++; $display("FAIL rnd_ack i%0d: got %b want 1", i, a0); end
            if (a1 !== 1'b0) begin n_fail++; $display("FAIL rnd_ack_gap i%0d: got %b want 0", i, a1); end
            if (we) begin
                m_write(off, sel, dat, w);
                if (irq0 !== m_irq(w)) begin
                    n_fail++; $display("FAIL rnd_irq i%0d off%0d: got %b want %b", i, off, irq0, m_irq(w));
                end
            end else begin
                exp32 = m_read(off, w);
                if (rd !== exp32) begin
                    n_fail++; $display("FAIL rnd_read i%0d off%0d: got %h want %h", i, off, rd, exp32);
                end
            end
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
    endtask

    task automatic test_reset_mid();
        longint r;
        @(negedge clk);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = 1'b1;
        bus.sel   = 4'hF;
        bus.adr   = 32'h0000_0008;
        bus.dat_w = 32'd0;
        reset     = 1'b1;
        @(posedge clk); #1 r = edge_cnt;
        n_checks++;
        if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL midrst_ack: got %b want 0", bus.ack); end
        @(negedge clk);
        reset   = 1'b0;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        @(posedge clk); #1;
        n_checks += 2;
        if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL midrst_ack_late: got %b want 0", bus.ack); end
        if (o_irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b want 0", o_irq); end
        m_reset(r);
        for (int off = 0; off < 8; off++) begin
            xfer(1'b0, 3'(off), 4'hF, 32'd0, rd, w, a0, a1, irq0);
            exp32 = m_read(3'(off), w);
            n_checks++;
            if (rd !== exp32) begin n_fail++; $display("FAIL midrst_rd off%0d: got %h want %h", off, rd, exp32); end
        end
    endtask

    initial begin
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.sel   = 4'h0;
        bus.adr   = 32'd0;
        bus.dat_w = 32'd0;
        reset     = 1'b1;
        test_reset();
        test_count();
        test_carry();
        test_irq();
        test_bytes();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
